// File: rtl/eros_ext_slv_guard.sv
// Guard between the EROS external-slave OBI port and the fabric: one outstanding
// transaction, per-phase watchdog, fabricated error responses and sticky timeout status.
package eros_ext_slv_guard_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module eros_ext_slv_guard
  import eros_ext_slv_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    slv_req_i,
  output obi_resp_t   slv_resp_o,
  output obi_req_t    mst_req_o,
  input  obi_resp_t   mst_resp_i,
  input  logic        clear_err_i,
  output logic        err_o,
  output logic        err_we_o,
  output logic [31:0] err_addr_o,
  output logic        timeout_o
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [2:0] {StIdle, StReq, StRsp, StErr, StFlush} state_e;

  state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic        hold_we_q;
  logic [3:0]  hold_be_q;
  logic [31:0] hold_addr_q;
  logic [31:0] hold_wdata_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        err_we_q;
  logic [31:0] err_addr_q;
  logic        timeout_q;

  logic            at_limit;
  logic            gnt_to;
  logic            rsp_to;
  logic            flush_to;
  logic            timeout;
  logic [CntW-1:0] cnt_inc;

  // An awaited event arriving on the last allowed cycle beats the timeout.
  assign at_limit = (cnt_q == CntLast);
  assign gnt_to   = (state_q == StReq) && at_limit && !mst_resp_i.gnt;
  assign rsp_to   = (state_q == StRsp) && at_limit && !mst_resp_i.rvalid;
  assign flush_to = (state_q == StFlush) && at_limit && !mst_resp_i.rvalid;
  assign timeout  = gnt_to | rsp_to;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    slv_resp_o.gnt    = (state_q == StIdle) && slv_req_i.req;
    slv_resp_o.rvalid = rvalid_q;
    slv_resp_o.rdata  = rdata_q;
    mst_req_o.req     = (state_q == StReq);
    mst_req_o.we      = hold_we_q;
    mst_req_o.be      = hold_be_q;
    mst_req_o.addr    = hold_addr_q;
    mst_req_o.wdata   = hold_wdata_q;
    err_o             = err_q;
    err_we_o          = err_we_q;
    err_addr_o        = err_addr_q;
    timeout_o         = timeout_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_we_q     <= 1'b0;
      err_addr_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      rvalid_q  <= 1'b0;
      timeout_q <= timeout;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (slv_req_i.req) begin
            hold_we_q    <= slv_req_i.we;
            hold_be_q    <= slv_req_i.be;
            hold_addr_q  <= slv_req_i.addr;
            hold_wdata_q <= slv_req_i.wdata;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (mst_resp_i.gnt) begin
            state_q <= StRsp;
            cnt_q   <= '0;
          end else if (gnt_to) begin
            state_q  <= StErr;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rdata_q  <= ERR_RDATA;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRsp: begin
          if (mst_resp_i.rvalid) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rdata_q  <= mst_resp_i.rdata;
          end else if (rsp_to) begin
            // Answer upstream now; the late fabric response is swallowed in StFlush.
            state_q  <= StFlush;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rdata_q  <= ERR_RDATA;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StErr: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        StFlush: begin
          if (mst_resp_i.rvalid || flush_to) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase

      // A timeout beats a simultaneous clear, and then recaptures as the new first error.
      if (timeout) begin
        err_q <= 1'b1;
        if (!err_q || clear_err_i) begin
          err_we_q   <= hold_we_q;
          err_addr_q <= hold_addr_q;
        end
      end else if (clear_err_i) begin
        err_q      <= 1'b0;
        err_we_q   <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eros_ext_slv_guard.sv
// Directed bench for eros_ext_slv_guard (TIMEOUT_CYCLES = 4); upstream responses are
// checked by a scoreboard monitor against expected data and arrival cycle.
module tb_eros_ext_slv_guard;
  import eros_ext_slv_guard_pkg::*;

  localparam logic [31:0] ErrData = 32'hBADC_AB1E;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  obi_req_t    slv_req;
  obi_resp_t   slv_resp;
  obi_req_t    mst_req;
  obi_resp_t   mst_resp;
  logic        clear_err;
  logic        err;
  logic        err_we;
  logic [31:0] err_addr;
  logic        timeout;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rcnt = 0;
  int   tcnt = 0;
  exp_t q[$];

  eros_ext_slv_guard #(
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA     (ErrData)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .clear_err_i(clear_err),
    .err_o      (err),
    .err_we_o   (err_we),
    .err_addr_o (err_addr),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor plus activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mst_req.req) rcnt++;
    if (timeout) tcnt++;
    if (slv_resp.rvalid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_rvalid", 64'(slv_resp.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid_rdata", 64'(slv_resp.rdata), 64'(e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Present an upstream request until granted; returns the grant cycle.
  task automatic up_req(input logic we, input logic [31:0] addr, output int gcyc);
    logic seen;
    seen          = 1'b0;
    gcyc          = cyc;
    slv_req.req   = 1'b1;
    slv_req.we    = we;
    slv_req.be    = 4'hF;
    slv_req.addr  = addr;
    slv_req.wdata = ~addr;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (slv_resp.gnt) begin
        seen = 1'b1;
        gcyc = cyc;
        break;
      end
      tick();
    end
    chk("upstream_gnt", 64'(seen), 64'd1);
    tick();
    slv_req.req = 1'b0;
  endtask

  task automatic gnt_timeout(input logic we, input logic [31:0] addr, input logic clr);
    int g;
    up_req(we, addr, g);
    q.push_back('{ErrData, g + 5});
    wait_cyc(g + 4);
    clear_err = clr;
    wait_cyc(g + 5);
    clear_err = 1'b0;
    wait_cyc(g + 6);
  endtask

  initial begin
    int g, g2;
    rst       = 1'b1;
    slv_req   = '0;
    mst_resp  = '0;
    clear_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("rst_mst_req", 64'(|mst_req), 64'd0);
    chk("rst_rvalid", 64'(slv_resp.rvalid), 64'd0);
    chk("rst_rdata", 64'(slv_resp.rdata), 64'd0);
    chk("rst_err", 64'({err, err_we, err_addr, timeout}), 64'd0);
    tick();

    // Best-case read.
    up_req(1'b0, 32'h1000_0000, g);
    q.push_back('{32'h1234_5678, g + 3});
    chk("read_mst_req", 64'({mst_req.req, mst_req.we}), 64'b10);
    chk("read_mst_addr", 64'(mst_req.addr), 64'h1000_0000);
    mst_resp.gnt = 1'b1;
    wait_cyc(g + 2);
    mst_resp.gnt    = 1'b0;
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'h1234_5678;
    wait_cyc(g + 3);
    mst_resp.rvalid = 1'b0;
    wait_cyc(g + 4);
    chk("read_err", 64'(err), 64'd0);

    // Grant timeout on a write.
    rcnt = 0;
    tcnt = 0;
    gnt_timeout(1'b1, 32'h2000_0010, 1'b0);
    chk("gto_req_cycles", 64'(rcnt), 64'd4);
    chk("gto_pulses", 64'(tcnt), 64'd1);
    chk("gto_err", 64'({err, err_we}), 64'b11);
    chk("gto_err_addr", 64'(err_addr), 64'h2000_0010);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    #2;
    chk("clear_status", 64'({err, err_we, err_addr}), 64'd0);
    tick();

    // Response timeout, late rvalid discarded in flush, then a normal read.
    tcnt = 0;
    up_req(1'b0, 32'h3000_0000, g);
    q.push_back('{ErrData, g + 6});
    mst_resp.gnt = 1'b1;
    wait_cyc(g + 2);
    mst_resp.gnt  = 1'b0;
    slv_req.req   = 1'b1;
    slv_req.we    = 1'b0;
    slv_req.addr  = 32'h3000_0004;
    for (int c = g + 2; c <= g + 8; c++) begin
      wait_cyc(c);
      if (c == g + 8) begin
        mst_resp.rvalid = 1'b1;
        mst_resp.rdata  = 32'hDEAD_BEEF;
      end
      #2;
      chk("busy_no_gnt", 64'(slv_resp.gnt), 64'd0);
    end
    wait_cyc(g + 9);
    mst_resp.rvalid = 1'b0;
    up_req(1'b0, 32'h3000_0004, g2);
    chk("regrant_cycle", 64'(g2), 64'(g + 9));
    q.push_back('{32'hCAFE_0001, g2 + 3});
    mst_resp.gnt = 1'b1;
    wait_cyc(g2 + 2);
    mst_resp.gnt    = 1'b0;
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'hCAFE_0001;
    wait_cyc(g2 + 3);
    mst_resp.rvalid = 1'b0;
    wait_cyc(g2 + 4);
    chk("rto_pulses", 64'(tcnt), 64'd1);
    chk("rto_err", 64'({err, err_we}), 64'b10);
    chk("rto_err_addr", 64'(err_addr), 64'h3000_0000);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // Response lands on the last allowed cycle: data wins, no timeout.
    tcnt = 0;
    up_req(1'b0, 32'h4000_0000, g);
    q.push_back('{32'h0BAD_F00D, g + 6});
    mst_resp.gnt = 1'b1;
    wait_cyc(g + 2);
    mst_resp.gnt = 1'b0;
    wait_cyc(g + 5);
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'h0BAD_F00D;
    wait_cyc(g + 6);
    mst_resp.rvalid = 1'b0;
    wait_cyc(g + 7);
    chk("edge_no_pulse", 64'(tcnt), 64'd0);
    chk("edge_no_err", 64'(err), 64'd0);

    // First error wins; a timeout colliding with clear recaptures.
    gnt_timeout(1'b0, 32'h6000_0000, 1'b0);
    gnt_timeout(1'b1, 32'h6000_0100, 1'b0);
    chk("first_err_addr", 64'(err_addr), 64'h6000_0000);
    chk("first_err_we", 64'({err, err_we}), 64'b10);
    gnt_timeout(1'b1, 32'h6000_0200, 1'b1);
    chk("collide_err_addr", 64'(err_addr), 64'h6000_0200);
    chk("collide_err_we", 64'({err, err_we}), 64'b11);

    // Reset while waiting for the fabric response.
    up_req(1'b0, 32'h5000_0000, g);
    mst_resp.gnt = 1'b1;
    wait_cyc(g + 2);
    mst_resp.gnt = 1'b0;
    rst          = 1'b1;
    wait_cyc(g + 3);
    rst = 1'b0;
    #2;
    chk("mid_rst_mst_req", 64'(|mst_req), 64'd0);
    chk("mid_rst_rvalid", 64'(slv_resp.rvalid), 64'd0);
    chk("mid_rst_rdata", 64'(slv_resp.rdata), 64'd0);
    chk("mid_rst_err", 64'({err, err_we, err_addr, timeout}), 64'd0);
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'h7777_7777;
    tick();
    mst_resp.rvalid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
